// File: rtl/dcache_direct_wt.sv
// dcache_direct_wt: direct-mapped, write-through, no-write-allocate data cache
// sitting between the MEM stage and a byte-addressed RAM. The RAM has a
// combinational word read and a synchronous word write.
//
// Ports:
//   clock, reset_n           - clock, async active-low reset
//   cpu_address/wdata        - MEM-stage byte address and store data
//   cpu_read/cpu_write       - load / store request (write wins if both)
//   cpu_rdata, cpu_stall     - load data (valid when read & !stall), freeze
//   mem_address/value/write  - word-aligned RAM address, write data, enable
//   mem_data                 - RAM combinational read data
//   hit_count, miss_count    - read hit / miss counters (wrap mod 2^32)
module dcache_direct_wt #(
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [31:0] mem_address,
  output logic [31:0] mem_value,
  output logic        mem_write,
  input  logic [31:0] mem_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 30 - OB - IB;   // tag width
  localparam int BW = TW + IB;        // line base {tag,index}

  typedef enum logic {IDLE, REFILL} state_t;

  logic [OB-1:0]    offset;
  logic [IB-1:0]    index;
  logic [TW-1:0]    tag;
  logic [31:0]      data_q [LINES*WORDS];
  logic [TW-1:0]    tag_q  [LINES];
  logic [LINES-1:0] valid_q;
  state_t           state_q, state_d;
  logic [BW-1:0]    base_q;
  logic [OB-1:0]    cnt_q;

  logic hit, do_write, rd_hit, rd_miss, refill_last;
  logic [IB-1:0]    refill_index;
  logic unused_lsbs;

  assign offset       = cpu_address[OB+1:2];
  assign index        = cpu_address[OB+IB+1:OB+2];
  assign tag          = cpu_address[31:OB+IB+2];
  assign unused_lsbs  = ^cpu_address[1:0];
  assign refill_index = base_q[IB-1:0];

  assign hit = valid_q[index] && (tag_q[index] == tag);

  // All request decodes are gated by reset_n so nothing touches the arrays
  // on a clock edge that lands while reset is held.
  assign do_write    = reset_n && (state_q == IDLE) && cpu_write;
  assign rd_hit      = reset_n && (state_q == IDLE) && !cpu_write && cpu_read && hit;
  assign rd_miss     = reset_n && (state_q == IDLE) && !cpu_write && cpu_read && !hit;
  assign refill_last = (state_q == REFILL) && (cnt_q == OB'(WORDS-1));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_miss)     state_d = REFILL;
      REFILL:  if (refill_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: forced to zero while reset is asserted
  always_comb begin
    cpu_rdata   = '0;
    cpu_stall   = 1'b0;
    mem_address = '0;
    mem_value   = '0;
    mem_write   = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (cpu_write) begin
            mem_address = {cpu_address[31:2], 2'b00};
            mem_value   = cpu_wdata;
            mem_write   = 1'b1;
          end else if (cpu_read) begin
            mem_address = {cpu_address[31:2], 2'b00};
            if (hit) cpu_rdata = data_q[{index, offset}];
            else     cpu_stall = 1'b1;
          end
        end
        REFILL: begin
          cpu_stall   = 1'b1;
          mem_address = {base_q, cnt_q, 2'b00};
        end
        default: ;
      endcase
    end
  end

  // Control state: refill bookkeeping, valid bits, counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      cnt_q      <= '0;
      valid_q    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit) hit_count <= hit_count + 32'd1;
      if (rd_miss) begin
        miss_count <= miss_count + 32'd1;
        base_q     <= {tag, index};
        cnt_q      <= '0;
        // Line is rewritten word by word; keep it invalid until complete.
        valid_q[index] <= 1'b0;
      end
      if (state_q == REFILL) begin
        cnt_q <= cnt_q + OB'(1);
        if (refill_last) begin
          cnt_q                 <= '0;
          valid_q[refill_index] <= 1'b1;
        end
      end
    end
  end

  // Storage arrays, not reset; valid bits guard their contents
  always_ff @(posedge clock) begin
    if (state_q == REFILL) begin
      data_q[{refill_index, cnt_q}] <= mem_data;
      if (refill_last) tag_q[refill_index] <= base_q[BW-1:IB];
    end else if (do_write && hit) begin
      data_q[{index, offset}] <= cpu_wdata;
    end
  end
endmodule

// File: tb/tb_dcache_direct_wt.sv
module tb_dcache_direct_wt;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cpu_address = '0, cpu_wdata = '0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_rdata, mem_address, mem_value, mem_data;
  logic        cpu_stall, mem_write;
  logic [31:0] hit_count, miss_count;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] expq [$];
  logic [31:0] ram [0:255];

  dcache_direct_wt #(.LINES(8), .WORDS(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_address(mem_address), .mem_value(mem_value), .mem_write(mem_write),
    .mem_data(mem_data), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  // RAM: combinational read, synchronous write
  assign mem_data = ram[mem_address[9:2]];
  always @(posedge clock) if (mem_write) ram[mem_address[9:2]] <= mem_value;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted load is compared against the scoreboard
  always @(negedge clock) begin
    if (reset_n === 1'b1 && cpu_read === 1'b1 && cpu_stall === 1'b0) begin
      if (expq.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL rdata_unexpected: got %h expected none", cpu_rdata);
      end else begin
        check("rdata", cpu_rdata, expq.pop_front());
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Issue a load, count stall cycles and check refill addresses
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input bit miss);
    int stalls = 0;
    logic [31:0] base;
    base = addr & ~32'hF;
    expq.push_back(exp);
    cpu_address = addr; cpu_read = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (!cpu_stall) break;
      if (stalls >= 1) check("refill_addr", mem_address, base + 32'(4 * (stalls - 1)));
      stalls++;
    end
    @(posedge clock);
    #1 cpu_read = 1'b0;
    check("stall_cycles", 32'(stalls), miss ? 32'd5 : 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] val);
    cpu_address = addr; cpu_wdata = val; cpu_write = 1'b1;
    @(negedge clock);
    check("wr_stall", {31'd0, cpu_stall}, 32'd0);
    check("wr_mem_write", {31'd0, mem_write}, 32'd1);
    check("wr_mem_address", mem_address, addr & ~32'h3);
    check("wr_mem_value", mem_value, val);
    @(posedge clock);
    #1 cpu_write = 1'b0;
    check("ram_after_write", ram[addr[9:2]], val);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    for (int i = 0; i < 4; i++) begin
      ram[4 + i]  = 32'hA000_0001 + 32'(i);   // 0x10..0x1C
      ram[16 + i] = 32'hC000_0001 + 32'(i);   // 0x40..0x4C
      ram[36 + i] = 32'hB000_0001 + 32'(i);   // 0x90..0x9C
    end

    do_reset();
    @(negedge clock);
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);

    // Cold miss then hit on the refilled word
    @(posedge clock); #1;
    do_read(32'h14, 32'hA000_0002, 1'b1);
    check("miss_count_1", miss_count, 32'd1);
    check("hit_count_1", hit_count, 32'd1);
    do_read(32'h1C, 32'hA000_0004, 1'b0);
    check("hit_count_2", hit_count, 32'd2);

    // Write hit updates RAM and cache
    do_write(32'h18, 32'hDEAD_BEEF);
    do_read(32'h18, 32'hDEAD_BEEF, 1'b0);
    check("hit_count_3", hit_count, 32'd3);

    // Write miss: no allocation, later read misses
    do_write(32'h200, 32'h1234_5678);
    do_read(32'h200, 32'h1234_5678, 1'b1);
    check("miss_count_2", miss_count, 32'd2);
    check("hit_count_4", hit_count, 32'd4);

    // Conflict misses on index 1 from a clean cache
    do_reset();
    do_read(32'h10, 32'hA000_0001, 1'b1);
    do_read(32'h90, 32'hB000_0001, 1'b1);
    do_read(32'h10, 32'hA000_0001, 1'b1);
    check("conflict_misses", miss_count, 32'd3);
    check("conflict_hits", hit_count, 32'd3);
    do_read(32'h18, 32'hDEAD_BEEF, 1'b0);

    // Reset in the second refill cycle abandons the refill
    cpu_address = 32'h48; cpu_read = 1'b1;
    @(negedge clock);
    check("abort_miss_stall", {31'd0, cpu_stall}, 32'd1);
    @(negedge clock);
    @(negedge clock);
    check("abort_refill_addr", mem_address, 32'h44);
    #1 reset_n = 1'b0;
    #1;
    check("abort_rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("abort_rst_hits", hit_count, 32'd0);
    check("abort_rst_misses", miss_count, 32'd0);
    check("abort_rst_mem_addr", mem_address, 32'd0);
    check("abort_rst_rdata", cpu_rdata, 32'd0);
    cpu_read = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    do_read(32'h48, 32'hC000_0003, 1'b1);
    check("abort_misses", miss_count, 32'd1);
    check("abort_hits", hit_count, 32'd1);
    do_read(32'h40, 32'hC000_0001, 1'b0);

    repeat (2) @(posedge clock);
    nvec++;
    if (expq.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dcache_direct_wt.md
Name: dcache_direct_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipeline's MEM stage and the byte-addressed data RAM.
- The RAM has a combinational 32-bit big-endian word read at any byte address and a synchronous 4-byte write on the clock edge.
- The cache serves read hits with zero wait.
- On a read miss it stalls the pipeline and refills one line from RAM, one word per cycle.
- Writes go straight through to RAM and update the cached copy on a hit.

Parameters:
- LINES, 8, number of cache lines; power of two, at least 2.
- WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_address  in  32  byte address from the MEM stage; bits [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_read  in  1  load request.
- cpu_write  in  1  store request.
- cpu_rdata  out  32  load data; valid when cpu_read=1 and cpu_stall=0.
- cpu_stall  out  1  freezes the pipeline; the CPU holds address, data and request while it is high.
- mem_address  out  32  word-aligned byte address to RAM.
- mem_value  out  32  write data to RAM.
- mem_write  out  1  RAM write enable.
- mem_data  in  32  RAM combinational read data.
- hit_count  out  32  number of read hits.
- miss_count  out  32  number of read misses.

Behaviour:
- Address split, with OB=log2(WORDS) and IB=log2(LINES):
  - offset = addr[OB+1:2]
  - index = addr[OB+IB+1:OB+2]
  - tag = addr[31:OB+IB+2]
- Storage: data array of LINES*WORDS words, plus a tag and a valid bit per line. The arrays are not reset; only the valid bits are cleared.
- Reset (asynchronous):
  - all valid bits = 0, FSM = IDLE, refill counter = 0, hit_count = 0, miss_count = 0.
  - Outputs during reset: cpu_stall=0, mem_write=0, cpu_rdata=0, mem_address=0, mem_value=0.
  - Reset during a refill abandons the refill; the partial line stays invalid.
- hit = valid[index] & (tag_array[index]==tag).
- FSM states: IDLE, REFILL.
- IDLE:
  - cpu_write=1 (this takes priority over cpu_read if both are high): mem_address={addr[31:2],2'b00}, mem_value=cpu_wdata, mem_write=1, cpu_stall=0. On a hit, the cached word is updated on the same edge. On a miss, no allocation.
  - cpu_read=1 and hit: cpu_rdata = cached word, combinationally. cpu_stall=0. hit_count increments.
  - cpu_read=1 and miss: cpu_stall=1. Latch the line base {tag,index}. Counter=0. miss_count increments. Next state REFILL.
  - No request: outputs idle (mem_write=0, cpu_stall=0, cpu_rdata=0).
- REFILL:
  - cpu_stall=1, mem_write=0, mem_address={latched tag,index,counter,2'b00}.
  - Each edge writes mem_data into data[index][counter] and increments counter.
  - On counter==WORDS-1: set tag and valid for the line, clear counter, go to IDLE.
  - CPU requests are ignored in this state; no RAM writes occur.
- Latency:
  - Read hit: 0 extra cycles.
  - Read miss: cpu_stall is high for exactly WORDS+1 cycles. The retried read then hits and is counted as a hit (hit_count +1 after miss_count +1).
  - Write: 0 extra cycles.
- Counters wrap modulo 2^32. Writes are not counted.
- A line being refilled is not valid until its last word is stored. A write that was held during the stall completes in IDLE after the refill and updates the now-valid line.
- Cache contents always equal RAM for valid lines (write-through invariant).

Test Plan:
- Reset, then preload RAM words 0x10..0x1C with 0xA0000001..0xA0000004. Read 0x14 -> stall for 5 cycles, mem_address steps 0x10, 0x14, 0x18, 0x1C, then cpu_rdata=0xA0000002, miss_count=1, hit_count=1.
- Read 0x1C immediately after -> no stall, cpu_rdata=0xA0000004, no RAM address change required, hit_count=2.
- Write 0xDEADBEEF to 0x18 (hit), then read 0x18 -> RAM word at 0x18 = 0xDEADBEEF, read hits and returns 0xDEADBEEF with no stall.
- Write 0x12345678 to 0x200 (miss), then read 0x200 -> write causes no allocation and no stall; the read misses (miss_count +1) and after refill returns 0x12345678.
- Conflict miss (defaults):
  - Read 0x10, then read 0x90 (same index 1, different tag).
  - 0x90 misses and evicts the line; reading 0x10 again misses again. miss_count=3 in total.
- Assert reset_n=0 in the 2nd REFILL cycle, release, then read the same address -> cpu_stall=0 during reset, counters=0; the read misses and performs a full 4-word refill.
